// File: rtl/ixc_elastic_pkg.sv
// Shared types for the ixc_elastic family: stage state and occupancy codes.
package ixc_elastic_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

endpackage

// File: rtl/ixc_elastic_11.sv
// Two-entry registered skid stage for the 11-bit assign-template bus.
// All outputs decode from registered state; r_ready never depends on l_ready.
module ixc_elastic_11
  import ixc_elastic_pkg::*;
#(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] R,
  input  logic         r_valid,
  output logic         r_ready,
  output logic [W-1:0] L,
  output logic         l_valid,
  input  logic         l_ready,
  input  logic         flush,
  output logic [1:0]   occ
);

  state_t       state;
  logic [W-1:0] head;
  logic [W-1:0] skid;
  logic         push;
  logic         pop;

  assign r_ready = (state != FULL);
  assign l_valid = (state != EMPTY);
  assign L       = head;
  assign push    = r_valid & r_ready;
  assign pop     = l_valid & l_ready;

  always_comb begin
    occ = OCC_EMPTY;
    case (state)
      ONE:     occ = OCC_ONE;
      FULL:    occ = OCC_FULL;
      default: occ = OCC_EMPTY;
    endcase
  end

  // Data registers only load on push or a skid->head move, so R is never
  // sampled while r_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      head  <= '0;
      skid  <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            head  <= R;
            state <= ONE;
          end
        end
        ONE: begin
          case ({push, pop})
            2'b11: head <= R;
            2'b10: begin
              skid  <= R;
              state <= FULL;
            end
            2'b01: state <= EMPTY;
            default: state <= ONE;
          endcase
        end
        FULL: begin
          if (pop) begin
            head  <= skid;
            state <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_ixc_elastic_11.sv
// Directed + random bench for ixc_elastic_11 against a queue-based model.
module tb_ixc_elastic_11;

  localparam int W = 11;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] R;
  logic         r_valid;
  logic         r_ready;
  logic [W-1:0] L;
  logic         l_valid;
  logic         l_ready;
  logic         flush;
  logic [1:0]   occ;

  int n_chk  = 0;
  int n_fail = 0;

  logic [W-1:0] mq[$];
  logic [W-1:0] m_l;

  ixc_elastic_11 #(.W(W)) dut (
    .clk(clk), .rst(rst), .R(R), .r_valid(r_valid), .r_ready(r_ready),
    .L(L), .l_valid(l_valid), .l_ready(l_ready), .flush(flush), .occ(occ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle, advance the model across the edge, then check outputs.
  task automatic step(input logic rv, input logic [W-1:0] d, input logic lr,
                      input logic fl, input logic rs);
    bit do_push, do_pop;
    r_valid = rv; R = d; l_ready = lr; flush = fl; rst = rs;
    @(posedge clk);
    if (rs) begin
      mq.delete();
      m_l = '0;
    end else if (fl) begin
      mq.delete();
    end else begin
      do_pop  = (mq.size() > 0) && lr;
      do_push = rv && (mq.size() < 2);
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(d);
      if (mq.size() > 0) m_l = mq[0];
    end
    @(negedge clk);
    chk("L",       32'(L),       32'(m_l));
    chk("l_valid", 32'(l_valid), 32'(mq.size() > 0));
    chk("r_ready", 32'(r_ready), 32'(mq.size() < 2));
    chk("occ",     32'(occ),     32'(mq.size()));
  endtask

  initial begin
    m_l = '0;
    // Reset held two cycles with a valid word present: nothing captured.
    step(1'b1, 11'h7FF, 1'b0, 1'b0, 1'b1);
    step(1'b1, 11'h7FF, 1'b0, 1'b0, 1'b1);
    chk("rst_L", 32'(L), 32'h0);
    chk("rst_occ", 32'(occ), 32'h0);

    // Streaming at full rate.
    step(1'b1, 11'h001, 1'b1, 1'b0, 1'b0);
    chk("stream1", 32'(L), 32'h001);
    step(1'b1, 11'h002, 1'b1, 1'b0, 1'b0);
    chk("stream2", 32'(L), 32'h002);
    step(1'b1, 11'h003, 1'b1, 1'b0, 1'b0);
    chk("stream3", 32'(L), 32'h003);
    step(1'b0, 11'h000, 1'b1, 1'b0, 1'b0);

    // Backpressure fills both entries, then drains in order.
    step(1'b1, 11'h155, 1'b0, 1'b0, 1'b0);
    step(1'b1, 11'h2AA, 1'b0, 1'b0, 1'b0);
    chk("bp_full", 32'(occ), 32'd2);
    step(1'b1, 11'h2AA, 1'b0, 1'b0, 1'b0);
    chk("bp_hold", 32'(L), 32'h155);
    step(1'b0, 11'h000, 1'b1, 1'b0, 1'b0);
    chk("bp_next", 32'(L), 32'h2AA);
    step(1'b0, 11'h000, 1'b1, 1'b0, 1'b0);
    chk("bp_empty", 32'(occ), 32'd0);

    // Simultaneous push and pop while holding one word.
    step(1'b1, 11'h0A0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 11'h050, 1'b1, 1'b0, 1'b0);
    chk("pp_L", 32'(L), 32'h050);
    chk("pp_occ", 32'(occ), 32'd1);

    // Flush while full drops the concurrent push.
    step(1'b1, 11'h123, 1'b0, 1'b0, 1'b0);
    chk("fl_pre", 32'(occ), 32'd2);
    step(1'b1, 11'h3C3, 1'b0, 1'b1, 1'b0);
    chk("fl_occ", 32'(occ), 32'd0);
    step(1'b0, 11'h000, 1'b1, 1'b0, 1'b0);
    chk("fl_noval", 32'(l_valid), 32'd0);

    // Reset mid-operation, then normal traffic.
    step(1'b1, 11'h0F0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 11'h0F1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 11'h000, 1'b1, 1'b0, 1'b1);
    chk("mrst_L", 32'(L), 32'h0);
    step(1'b1, 11'h111, 1'b1, 1'b0, 1'b0);
    chk("mrst_push", 32'(L), 32'h111);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), W'($urandom),
           1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 40) == 0),
           1'($urandom_range(0, 80) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
